// File: rtl/cmd_gen_if.sv
// Request and byte-stream bundle between the sequencer, cmd_gen and the TX buffer.
// Latency: wires only.
// Backpressure: i_tx_full from the downstream buffer, o_cmd_ready toward the sequencer.
interface cmd_gen_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [3:0]  i_cmd_op;
    logic [23:0] i_cmd_arg;
    logic        o_data_valid;
    logic [7:0]  o_data;
    logic        i_tx_full;

    // Sequencer / downstream side
    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_arg, i_tx_full,
        input  o_cmd_ready, o_data_valid, o_data
    );

    // Encoder side
    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_arg, i_tx_full,
        output o_cmd_ready, o_data_valid, o_data
    );
endinterface

// File: rtl/cmd_gen.sv
// ASCII command encoder: opcode+argument request -> 4-char keyword plus optional hex/decimal digit bytes.
// Latency: first byte valid the cycle after accept; one byte per unstalled cycle.
// Backpressure: i_tx_full high holds the byte index and suppresses o_data_valid; requests accepted only when idle.
module cmd_gen #(
    parameter int ARG_DIGITS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    cmd_gen_if.slave    bus,
    output logic        o_busy,
    output logic        o_err,
    output logic [15:0] o_cmd_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KEY  = 2'd1;
    localparam logic [1:0] ARG  = 2'd2;

    localparam int         ARG_W    = 4 * ARG_DIGITS;
    localparam logic [7:0] LAST_DIG = 8'(ARG_DIGITS - 1);

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [ARG_W-1:0] arg_sh;   // wide argument, shifted left one nibble per emitted digit
    logic [7:0]       idx;
    logic             rdy_q;
    logic             dvld_q;
    logic [7:0]       data_q;

    logic             accept;
    logic             legal;
    logic             wide_arg;
    logic             short_arg;
    logic             last_byte;
    logic [7:0]       key_byte;
    logic [7:0]       arg_byte;

    assign bus.o_cmd_ready  = rdy_q;
    assign bus.o_data_valid = dvld_q;
    assign bus.o_data       = data_q;

    function automatic logic [7:0] kw_char(input logic [3:0] op, input logic [1:0] i);
        logic [31:0] w;
        case (op)
            4'd0:    w = "CMOD";
            4'd1:    w = "DMOD";
            4'd2:    w = "SADR";
            4'd3:    w = "SLEN";
            4'd4:    w = "SRST";
            4'd5:    w = "PICP";
            4'd6:    w = "RST1";
            4'd7:    w = "RST2";
            4'd8:    w = "CINT";
            4'd9:    w = "NCON";
            4'd10:   w = "RPRR";
            default: w = 32'h0;
        endcase
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Decode of the latched request and the byte due on the next free cycle
    always_comb begin
        accept    = (state == IDLE) && bus.i_cmd_valid && rdy_q;
        legal     = (bus.i_cmd_op <= 4'd10);
        wide_arg  = (op_q == 4'd2) || (op_q == 4'd3);
        short_arg = (op_q == 4'd8) || (op_q == 4'd9);
        key_byte  = kw_char(op_q, idx[1:0]);
        arg_byte  = wide_arg ? hex_char(arg_sh[ARG_W-1 -: 4])
                             : (8'h30 + {6'd0, arg_sh[1:0]});
        last_byte = ((state == KEY) && (idx == 8'd3) && !wide_arg && !short_arg) ||
                    ((state == ARG) && (short_arg || (idx == LAST_DIG)));
    end

    // Request acceptance, byte sequencing and completion counting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            op_q      <= 4'd0;
            arg_sh    <= '0;
            idx       <= 8'd0;
            rdy_q     <= 1'b0;
            dvld_q    <= 1'b0;
            data_q    <= 8'd0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            o_cmd_cnt <= 16'd0;
        end else begin
            o_err  <= 1'b0;
            dvld_q <= 1'b0;
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        op_q   <= bus.i_cmd_op;
                        arg_sh <= ARG_W'(bus.i_cmd_arg);
                        if (legal) begin
                            state  <= KEY;
                            idx    <= 8'd0;
                            rdy_q  <= 1'b0;
                            o_busy <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                KEY, ARG: begin
                    if (!bus.i_tx_full) begin
                        dvld_q <= 1'b1;
                        data_q <= (state == KEY) ? key_byte : arg_byte;
                        if ((state == ARG) && wide_arg) begin
                            arg_sh <= arg_sh << 4;
                        end
                        if (last_byte) begin
                            state     <= IDLE;
                            rdy_q     <= 1'b1;
                            o_busy    <= 1'b0;
                            o_cmd_cnt <= o_cmd_cnt + 16'd1;
                        end else if ((state == KEY) && (idx == 8'd3)) begin
                            state <= ARG;
                            idx   <= 8'd0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_gen.sv
// Bench for cmd_gen: directed scenarios plus randomized commands against a string-level model.
// Latency: checks first-byte timing and one idle slot between back-to-back commands.
// Backpressure: drives i_tx_full stalls (held, alternating, random).
module tb_cmd_gen;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_busy;
    logic        o_err;
    logic [15:0] o_cmd_cnt;

    cmd_gen_if bus();

    cmd_gen #(.ARG_DIGITS(6)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .bus       (bus),
        .o_busy    (o_busy),
        .o_err     (o_err),
        .o_cmd_cnt (o_cmd_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_cnt = 0;
    logic [7:0] got[$];
    int         got_t[$];
    logic [7:0] expq[$];
    string kw[11] = '{"CMOD", "DMOD", "SADR", "SLEN", "SRST", "PICP",
                      "RST1", "RST2", "CINT", "NCON", "RPRR"};

    always @(posedge i_clk) cyc <= cyc + 1;

    // Byte monitor: records every strobed byte with the edge count that produced it
    always @(negedge i_clk) begin
        if (bus.o_data_valid === 1'b1) begin
            got.push_back(bus.o_data);
            got_t.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference stream: keyword text, then hex digits of the 24-bit arg or one decimal digit
    task automatic build_exp(input int op, input logic [23:0] arg);
        string hx;
        string k;
        hx = "0123456789ABCDEF";
        expq.delete();
        if (op <= 10) begin
            k = kw[op];
            for (int i = 0; i < 4; i++) expq.push_back(k[i]);
            if (op == 2 || op == 3) begin
                for (int d = 5; d >= 0; d--) expq.push_back(hx[int'((arg >> (4 * d)) & 24'hF)]);
            end else if (op == 8 || op == 9) begin
                expq.push_back(8'h30 + 8'(arg % 4));
            end
        end
    endtask

    // Issue one request; mode: 0 no stall, 1 full for 3 cycles after accept, 2 alternating, 3 random
    task automatic issue(input int op, input logic [23:0] arg, input int mode,
                         output int acc, output logic b_acc, output logic r_acc,
                         output logic e_acc, output bit ok);
        int k;
        ok = 1'b0;
        for (k = 0; k < 50 && bus.o_cmd_ready !== 1'b1; k++) step();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 4'(op);
        bus.i_cmd_arg   = arg;
        bus.i_tx_full   = (mode == 1);
        step();
        acc   = cyc;
        b_acc = o_busy;
        r_acc = bus.o_cmd_ready;
        e_acc = o_err;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 4'($urandom_range(0, 15));
        bus.i_cmd_arg   = 24'($urandom);
        for (k = 0; k < 100; k++) begin
            case (mode)
                0:       bus.i_tx_full = 1'b0;
                1:       bus.i_tx_full = (k < 3);
                2:       bus.i_tx_full = (k % 2 == 1);
                default: bus.i_tx_full = 1'($urandom_range(0, 1));
            endcase
            step();
            if (bus.o_cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.i_tx_full = 1'b0;
        step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 4'd0;
        bus.i_cmd_arg   = 24'd0;
        bus.i_tx_full   = 1'b0;
        step(); step(); step();
        n_vec++; if (bus.o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.o_cmd_ready); end
        n_vec++; if (bus.o_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.o_data_valid); end
        n_vec++; if (bus.o_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", bus.o_data); end
        n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        n_vec++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", o_err); end
        n_vec++; if (o_cmd_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", o_cmd_cnt); end
        i_rst = 1'b0;
        step();
        n_vec++; if (bus.o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", bus.o_cmd_ready); end
    endtask

    task automatic test_sadr();
        int acc; logic b, r, e; bit ok;
        got.delete(); got_t.delete();
        issue(2, 24'h01A2F0, 0, acc, b, r, e, ok);
        build_exp(2, 24'h01A2F0);
        exp_cnt++;
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sadr_done: got timeout want completion"); end
        n_vec++; if (b !== 1'b1 || r !== 1'b0) begin n_bad++; $display("FAIL sadr_accept: got busy %b ready %b want 1 0", b, r); end
        n_vec++; if (got.size() != 10) begin n_bad++; $display("FAIL sadr_len: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_vec++; if (got[i] !== expq[i] || got_t[i] != acc + 1 + i) begin
                n_bad++; $display("FAIL sadr_byte%0d: got %h@%0d want %h@%0d", i, got[i], got_t[i], expq[i], acc + 1 + i);
            end
        end
        n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sadr_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    endtask

    task automatic test_stall();
        int acc; logic b, r, e; bit ok;
        got.delete(); got_t.delete();
        issue(5, 24'h123456, 1, acc, b, r, e, ok);
        build_exp(5, 24'h0);
        exp_cnt++;
        n_vec++; if (!ok) begin n_bad++; $display("FAIL picp_done: got timeout want completion"); end
        n_vec++; if (got.size() != 4) begin n_bad++; $display("FAIL picp_len: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_vec++; if (got[i] !== expq[i] || got_t[i] != acc + 4 + i) begin
                n_bad++; $display("FAIL picp_byte%0d: got %h@%0d want %h@%0d", i, got[i], got_t[i], expq[i], acc + 4 + i);
            end
        end
        n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL picp_busy: got %b want 0", o_busy); end
        n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL picp_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    endtask

    task automatic test_toggle();
        int acc; logic b, r, e; bit ok;
        got.delete(); got_t.delete();
        issue(3, 24'hFFFFFF, 2, acc, b, r, e, ok);
        build_exp(3, 24'hFFFFFF);
        exp_cnt++;
        n_vec++; if (!ok) begin n_bad++; $display("FAIL slen_done: got timeout want completion"); end
        n_vec++; if (got.size() != expq.size()) begin n_bad++; $display("FAIL slen_len: got %0d want %0d", got.size(), expq.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_vec++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL slen_byte%0d: got %h want %h", i, got[i], expq[i]); end
        end
        n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL slen_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, k;
        bit found;
        logic [7:0] want[$];
        got.delete(); got_t.delete();
        for (k = 0; k < 50 && bus.o_cmd_ready !== 1'b1; k++) step();
        bus.i_cmd_valid = 1'b1; bus.i_cmd_op = 4'd8; bus.i_cmd_arg = 24'd2;
        step();
        acc1 = cyc;
        bus.i_cmd_op = 4'd9; bus.i_cmd_arg = 24'd3;
        found = 1'b0;
        for (k = 0; k < 50; k++) begin
            step();
            if (bus.o_cmd_ready === 1'b1) begin found = 1'b1; break; end
        end
        step();
        acc2 = cyc;
        bus.i_cmd_valid = 1'b0;
        for (k = 0; k < 50 && bus.o_cmd_ready !== 1'b1; k++) step();
        step();
        build_exp(8, 24'd2); want = expq;
        build_exp(9, 24'd3); want = {want, expq};
        exp_cnt += 2;
        n_vec++; if (!found) begin n_bad++; $display("FAIL b2b_ready: got timeout want ready"); end
        n_vec++; if (acc2 != acc1 + 6) begin n_bad++; $display("FAIL b2b_accept: got edge %0d want %0d", acc2, acc1 + 6); end
        n_vec++; if (got.size() != 10) begin n_bad++; $display("FAIL b2b_len: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_vec++; if (got[i] !== want[i] || got_t[i] != acc1 + 1 + i + (i >= 5 ? 1 : 0)) begin
                n_bad++; $display("FAIL b2b_byte%0d: got %h@%0d want %h@%0d", i, got[i], got_t[i], want[i], acc1 + 1 + i + (i >= 5 ? 1 : 0));
            end
        end
        n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        int k;
        got.delete(); got_t.delete();
        for (k = 0; k < 50 && bus.o_cmd_ready !== 1'b1; k++) step();
        bus.i_cmd_valid = 1'b1; bus.i_cmd_op = 4'd13; bus.i_cmd_arg = 24'h00ABCD;
        step();
        bus.i_cmd_valid = 1'b0;
        n_vec++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", o_err); end
        n_vec++; if (bus.o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", bus.o_cmd_ready); end
        n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy: got %b want 0", o_busy); end
        step();
        n_vec++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL ill_err_pulse: got %b want 0", o_err); end
        step(); step(); step();
        n_vec++; if (got.size() != 0) begin n_bad++; $display("FAIL ill_bytes: got %0d want 0", got.size()); end
        n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL ill_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        int k, nb;
        got.delete(); got_t.delete();
        for (k = 0; k < 50 && bus.o_cmd_ready !== 1'b1; k++) step();
        bus.i_cmd_valid = 1'b1; bus.i_cmd_op = 4'd6; bus.i_cmd_arg = 24'd0;
        step();
        bus.i_cmd_valid = 1'b0;
        nb = 0;
        for (k = 0; k < 20; k++) begin
            step();
            if (bus.o_data_valid === 1'b1) nb++;
            if (nb == 2) break;
        end
        n_vec++; if (nb != 2) begin n_bad++; $display("FAIL rmid_bytes_seen: got %0d want 2", nb); end
        i_rst = 1'b1;
        step();
        n_vec++; if (bus.o_data_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", bus.o_data_valid); end
        n_vec++; if (o_cmd_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", o_cmd_cnt); end
        step();
        i_rst = 1'b0;
        exp_cnt = 0;
        step();
        n_vec++; if (bus.o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", bus.o_cmd_ready); end
        step(); step(); step(); step();
        n_vec++; if (got.size() != 2) begin n_bad++; $display("FAIL rmid_total: got %0d want 2", got.size()); end
        n_vec++; if (got.size() == 2 && (got[0] !== 8'h52 || got[1] !== 8'h53)) begin
            n_bad++; $display("FAIL rmid_prefix: got %h %h want 52 53", got[0], got[1]);
        end
    endtask

    task automatic test_random();
        int acc, op, mode; logic b, r, e; bit ok; logic [23:0] arg;
        for (int it = 0; it < 24; it++) begin
            op   = $urandom_range(0, 14);
            mode = $urandom_range(0, 3);
            arg  = 24'($urandom);
            got.delete(); got_t.delete();
            issue(op, arg, mode, acc, b, r, e, ok);
            build_exp(op, arg);
            if (op <= 10) exp_cnt++;
            n_vec++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_done: got timeout want completion", it); end
            n_vec++; if (e !== (op > 10)) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b op %0d", it, e, op > 10, op); end
            n_vec++; if (got.size() != expq.size()) begin n_bad++; $display("FAIL rnd%0d_len: got %0d want %0d op %0d", it, got.size(), expq.size(), op); end
            for (int i = 0; i < got.size() && i < expq.size(); i++) begin
                n_vec++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d: got %h want %h op %0d", it, i, got[i], expq[i], op); end
            end
            if (mode == 0 && op <= 10 && got.size() == expq.size()) begin
                n_vec++; if (got_t[0] != acc + 1 || got_t[got.size() - 1] != acc + got.size()) begin
                    n_bad++; $display("FAIL rnd%0d_timing: got %0d..%0d want %0d..%0d", it, got_t[0], got_t[got.size() - 1], acc + 1, acc + got.size());
                end
            end
            n_vec++; if (o_cmd_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", it, o_cmd_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_sadr();
        test_stall();
        test_toggle();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
